spi_loader_master: RTL
======================

// Module: spi_loader_master
// PURPOSE
// - Fabric-side SPI master that drives the PULPino SoC SPI slave port (spi_clk_i/spi_cs_i/spi_sdi0_i/spi_sdo0_o).
// - Loads and reads PULPino memory from the ps7_clk domain without PS7 SPI0 software bit timing.
// - Accepts one 32-bit word transaction per valid/ready request; returns a response pulse.
// - Single-lane (standard) SPI only: mode 0, MSB first.
// PARAMETERS
// - CLK_DIV       2    ps7_clk cycles per SCK half-period; legal range >=1.
// - DUMMY_CYCLES  32   SCK cycles between address and read data; must match the slave dummy register.
// - CMD_WRITE     8'h02  Slave memory-write command byte.
// - CMD_READ      8'h0B  Slave memory-read command byte.
// PORTS
// - ps7_clk      in   1   Clock; all logic on rising edge.
// - ps7_rst_n    in   1   Asynchronous, active-low reset.
// - req_valid_i  in   1   Request valid.
// - req_ready_o  out  1   Request accepted on the cycle where valid&&ready.
// - req_we_i     in   1   1 = write, 0 = read.
// - req_addr_i   in   32  Target byte address in PULPino memory space.
// - req_wdata_i  in   32  Write data; ignored for reads.
// - rsp_valid_o  out  1   One-cycle pulse when a transaction completes (write and read).
// - rsp_rdata_o  out  32  Read data; held until the next read completes; 0 after writes is NOT forced.
// - busy_o       out  1   High from acceptance until rsp_valid_o, inclusive.
// - spi_sck_o    out  1   SPI clock; idles low.
// - spi_cs_o     out  1   Chip select, active low; idles high.
// - spi_mosi_o   out  1   Master data out.
// - spi_miso_i   in   1   Slave data in.
// BEHAVIOUR
// - Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0, spi_sck_o=0, spi_cs_o=1, spi_mosi_o=0, FSM=IDLE.
// - All outputs are registered.
// - Request handshake:
//   - req_ready_o=1 only in IDLE.
//   - On valid&&ready, the request is latched and ready drops the next cycle.
//   - Inputs are don't-care while busy.
// - FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   - SETUP: cs_o low for CLK_DIV cycles; mosi_o = bit 7 of the command.
//   - SHIFT, bit sequence:
//     - write: CMD[7:0], ADDR[31:0], WDATA[31:0] = 72 bits.
//     - read: CMD[7:0], ADDR[31:0], DUMMY_CYCLES don't-care bits (mosi_o=0), then 32 RX bits.
//   - Each bit lasts 2*CLK_DIV cycles: sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - mosi_o updates on the cycle sck falls, or enters SETUP for the first bit.
//   - miso_i sampling (read, data phase only):
//     - Sampled into the RX shift register on the ps7_clk edge that drives sck high->low.
//     - Shifted MSB first; the first sampled bit lands in rdata[31].
//   - HOLD: after the last falling sck edge, cs_o stays low CLK_DIV cycles, then cs_o=1.
//   - GAP: cs_o high for CLK_DIV cycles.
//     - On the last GAP cycle: rsp_valid_o=1; for reads, rsp_rdata_o is updated on the same edge.
//     - Return to IDLE with ready=1 on the following cycle.
// - Bit counter: 7-bit minimum, sized for 72+DUMMY_CYCLES; no wrap inside a transaction.
// - Latency, acceptance edge to rsp_valid_o:
//   - write: CLK_DIV*(1 + 144 + 1 + 1) cycles.
//   - read: CLK_DIV*(1 + 2*(72+DUMMY_CYCLES) + 1 + 1) cycles.
// - CLK_DIV=1: sck toggles every ps7_clk cycle; same ordering rules apply.
// - Async reset mid-transfer: outputs return to reset values immediately; any partial RX data is discarded; no rsp pulse.
// - A request presented together with rsp_valid_o is not accepted until the IDLE cycle (ready=1).
// TESTING
// - Write, CLK_DIV=2, addr=0x0010_0000, wdata=0xDEADBEEF.
//   -> SPI model captures 0x02, 0x00100000, 0xDEADBEEF.
//   -> 72 sck rising edges; rsp_valid_o exactly 294 cycles after acceptance.
// - Read, CLK_DIV=2, DUMMY_CYCLES=32, addr=0x0000_2000; model drives 0x12345678 after dummy.
//   -> rsp_rdata_o=0x12345678.
//   -> 104 sck rising edges; mosi_o=0 during dummy bits.
// - Back-to-back: second req_valid held high during the first write.
//   -> req_ready_o low throughout the first transfer.
//   -> cs_o high >=CLK_DIV cycles between transfers.
//   -> second accepted exactly one cycle after the rsp pulse.
// - CLK_DIV=1 write of 0xA5A5A5A5 to 0xFFFF_FFFC.
//   -> correct bitstream; sck period = 2 ps7_clk cycles; latency 147 cycles.
// - Assert ps7_rst_n low at bit 40 of a read.
//   -> same cycle: cs_o=1, sck_o=0, req_ready_o=1.
//   -> no rsp_valid_o.
//   -> next read returns correct data.
// - Idle check: 1000 cycles with no request.
//   -> sck_o=0, cs_o=1, busy_o=0, rsp_valid_o never asserted.

Source files
------------

// File: rtl/spi_loader_master.sv
// spi_loader_master: fabric-side SPI master (mode 0, MSB first, single lane)
// that turns one 32-bit read or write request into a PULPino SPI-slave
// memory transaction and returns a one-cycle response pulse.
//
// Handshake: a request is taken on the rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only while idle, so inputs
// are ignored for the whole transfer. rsp_valid_o is a single-cycle pulse
// with no back-pressure; rsp_rdata_o is valid with it and held afterwards.
module spi_loader_master #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter logic [7:0]  CMD_WRITE    = 8'h02,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        ps7_clk,
  input  logic        ps7_rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i,
  output logic [2:0]  dbg_state_o
);

  // Frame geometry: writes are cmd+addr+data, reads are cmd+addr+dummy+data.
  localparam int unsigned RD_BITS  = 72 + DUMMY_CYCLES;
  localparam int unsigned RX_FIRST = 40 + DUMMY_CYCLES;
  localparam int unsigned BIT_W    = ($clog2(RD_BITS) > 7) ? $clog2(RD_BITS) : 7;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Phase count one before the last GAP cycle (only meaningful for CLK_DIV>=2).
  localparam logic [DIV_W-1:0] DIV_PRE  = (CLK_DIV >= 2) ? DIV_W'(CLK_DIV - 2) : '0;
  localparam bit               DIV_ONE  = (CLK_DIV == 1);
  localparam logic [BIT_W-1:0] LAST_WR  = BIT_W'(71);
  localparam logic [BIT_W-1:0] LAST_RD  = BIT_W'(RD_BITS - 1);
  localparam logic [BIT_W-1:0] RX_START = BIT_W'(RX_FIRST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        rx_q, rx_d;
  logic [71:0]        tx_q, tx_d;
  logic               we_q, we_d;

  logic               div_last;
  logic               bit_last;

  // State and datapath registers; reset puts the SPI lines in their idle levels.
  always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
    if (!ps7_rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      we_q        <= we_d;
    end
  end

  // Next-state and next-output logic; every phase lasts CLK_DIV cycles.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sck_d       = sck_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    we_d        = we_q;

    div_last = (div_q == DIV_LAST);
    bit_last = we_q ? (bit_q == LAST_WR) : (bit_q == LAST_RD);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          state_d = S_SETUP;
          div_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          we_d    = req_we_i;
          rx_d    = '0;
          // Read frames carry zeros after the address, which covers the
          // dummy bits; the shift register keeps feeding zeros beyond that.
          tx_d    = req_we_i ? {CMD_WRITE, req_addr_i, req_wdata_i}
                             : {CMD_READ, req_addr_i, 32'h0};
          mosi_d  = req_we_i ? CMD_WRITE[7] : CMD_READ[7];
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_SHIFT;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: the slave's bit is still stable here, and the
            // next MOSI bit is launched on the same edge.
            sck_d = 1'b0;
            if (!we_q && (bit_q >= RX_START)) begin
              rx_d = {rx_q[30:0], spi_miso_i};
            end
            if (bit_last) begin
              state_d = S_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d  = bit_q + 1'b1;
              tx_d   = {tx_q[70:0], 1'b0};
              mosi_d = tx_q[70];
            end
          end
        end
      end
      S_HOLD: begin
        if (div_last) begin
          state_d = S_GAP;
          div_d   = '0;
          cs_d    = 1'b1;
          // With a one-cycle GAP the response is launched as GAP is entered.
          if (DIV_ONE) begin
            rsp_valid_d = 1'b1;
            if (!we_q) begin
              rdata_d = rx_q;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_last) begin
          state_d = S_IDLE;
          div_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
          if (div_q == DIV_PRE) begin
            rsp_valid_d = 1'b1;
            if (!we_q) begin
              rdata_d = rx_q;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = busy_q;
  assign spi_sck_o   = sck_q;
  assign spi_cs_o    = cs_q;
  assign spi_mosi_o  = mosi_q;
  assign dbg_state_o = state_q;

endmodule
